// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_pkg
// Purpose  : Shared constants for the key debounce / LED channel slice:
//            board clock, debounce window, key/LED polarities and LED modes.
// Revision : 1.0  initial release
// ============================================================================
package key_pkg;

    localparam int   CLK_FREQ_HZ             = 50000000;
    localparam int   DEBOUNCE_MS             = 20;
    // 20 ms at 50 MHz = 1,000,000 cycles
    localparam int   DEBOUNCE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

    // Raw pin level that means "pressed", and LED drive level that means "lit"
    localparam logic KEY_ACTIVE_LEVEL        = 1'b0;
    localparam logic LED_ON_LEVEL            = 1'b1;

    localparam int   LED_MODE_FOLLOW         = 0;
    localparam int   LED_MODE_TOGGLE         = 1;

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_ch
// Purpose  : One key/LED channel: 2-flop synchroniser, stability counter,
//            debounced level, press/release pulses and LED drive.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            key_i          - raw asynchronous key pin (0 = pressed)
//            level_o        - debounced level (1 = pressed)
//            press_o        - one-cycle pulse on debounced press
//            release_o      - one-cycle pulse on debounced release
//            led_o          - LED drive (1 = lit)
// Revision : 1.0  initial release
// ============================================================================
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LED_MODE        = LED_MODE_FOLLOW
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic led_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchroniser holds the raw pin polarity; reset value 1 = released.
    logic             sync1_q;
    logic             sync2_q;
    logic             w_s2;

    logic             stable_q,  stable_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;
    logic             led_q,     led_d;

    assign w_s2 = (sync2_q == KEY_ACTIVE_LEVEL);

    // Counter only advances while the synchronised key disagrees with the
    // accepted level; any agreement discards the partial count. It stops at
    // CNT_LAST because reaching it always accepts the new level and clears.
    always_comb begin
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (w_s2 == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d  = w_s2;
            cnt_d     = '0;
            press_d   = w_s2;
            release_d = ~w_s2;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    generate
        if (LED_MODE == LED_MODE_TOGGLE) begin : g_led_toggle
            assign led_d = led_q ^ press_d;
        end else begin : g_led_follow
            assign led_d = stable_d;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            stable_q  <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            led_q     <= ~LED_ON_LEVEL;
        end else begin
            sync1_q   <= key_i;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            led_q     <= led_d;
        end
    end

    assign level_o   = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign led_o     = led_q;

endmodule : key_debounce_ch
`default_nettype wire

// File: rtl/key_debounce_led.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_led
// Purpose  : N independent debounced push-button channels with press/release
//            pulses and LED drive (follow or toggle mode).
// Ports    : clk, rst       - clock, synchronous active-high reset
//            key_in         - raw active-low keys, asynchronous
//            key_level      - debounced levels (1 = pressed)
//            key_press      - one-cycle press pulses
//            key_release    - one-cycle release pulses
//            led_out        - LED drives (1 = lit)
// Revision : 1.0  initial release
// ============================================================================
module key_debounce_led
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LED_MODE        = LED_MODE_FOLLOW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] led_out
);

    generate
        for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
            key_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .LED_MODE        (LED_MODE)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .key_i     (key_in[i]),
                .level_o   (key_level[i]),
                .press_o   (key_press[i]),
                .release_o (key_release[i]),
                .led_o     (led_out[i])
            );
        end
    endgenerate

endmodule : key_debounce_led
`default_nettype wire

// File: doc/key_debounce_led.md
Name: key_debounce_led

Overview:
- Parametrised successor to the raw key-to-LED latch path. Synchronises N active-low push-buttons and debounces each one with a per-channel stability counter.
- Per channel it provides a debounced level, one-cycle press and release pulses, and an LED drive. The LED drive either follows the key or toggles on each press.
- Sits between board key pins and LED pins or downstream control logic in all demo tops.

Parameters:
- N_KEYS, 4, number of independent key/LED channels (1..32).
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a new key level (20 ms at 50 MHz); must be ≥1.
- LED_MODE, 0, 0 = LED follows debounced press level; 1 = LED toggles on each debounced press.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  reset, synchronous, active-high.
- key_in  input  N_KEYS  raw buttons, asynchronous; 0 = pressed, 1 = released.
- key_level  output  N_KEYS  debounced state; 1 = pressed.
- key_press  output  N_KEYS  one-cycle pulse on debounced press.
- key_release  output  N_KEYS  one-cycle pulse on debounced release.
- led_out  output  N_KEYS  LED drive; 1 = lit.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); there is no asynchronous reset path.
- Reset state, applied at the first clk edge with rst=1:
  - both synchroniser stages = 1 (released);
  - stable = 0; counter = 0;
  - key_level, key_press, key_release, led_out = 0.
- Input synchroniser: per channel, a 2-flop chain on ~key_in gives the active-high signal s2. Nothing else samples key_in.
- Debounce state machine, per channel, is implicit in (stable, cnt):
  - s2 == stable: cnt <= 0. This includes a glitch returning before the count expires; the partial count is discarded.
  - s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0, and a pulse is registered at the same edge.
  - cnt width = $clog2(DEBOUNCE_CYCLES+1). The counter saturates structurally and never wraps.
- Latency: a clean level change on key_in captured at edge E0 appears on key_level at edge E0+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges inclusive.
- key_level = stable, registered.
- Pulses:
  - key_press = 1 for exactly one cycle, at the edge where stable goes 0->1.
  - key_release likewise for 1->0.
  - They are never both high on one channel.
  - A bounce shorter than DEBOUNCE_CYCLES produces no pulse.
- LED:
  - LED_MODE=0: led_out follows key_level, same value and same edge.
  - LED_MODE=1: led_out inverts at the edge key_press is asserted; release has no effect. Toggle state is held indefinitely.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses.
- Reset mid-operation (rst high during counting or while held pressed):
  - all state returns to reset values and partial counts are lost;
  - no pulse is emitted during or on the cycle after reset.
  - If the key is still pressed after rst falls, a press is re-detected after the full latency, and key_press fires.
- DEBOUNCE_CYCLES=1: a level is accepted after a single mismatch cycle (latency 3 edges).

Decomposition:
- Shared package key_pkg holds:
  - constant CLK_FREQ_HZ = 50000000;
  - DEBOUNCE_MS = 20 and the derived DEBOUNCE_CYCLES default;
  - KEY_ACTIVE_LEVEL = 0 and LED_ON_LEVEL = 1;
  - LED_MODE_FOLLOW = 0 and LED_MODE_TOGGLE = 1.
- Sub-module key_debounce_ch: one channel holding the synchroniser, counter, stable flop, pulses and LED logic. The top instantiates N_KEYS copies in a generate loop, with no shared logic.

Test Plan (N_KEYS=4, DEBOUNCE_CYCLES=4 unless stated):
- Reset: hold rst 3 cycles with key_in=4'b0000 -> all outputs 0 throughout. After release, key_level=4'b1111 exactly 6 edges later and key_press=4'b1111 for one cycle.
- Clean press on key 0: key_in 4'b1111->4'b1110 held 10 cycles -> key_level[0] rises 6 edges after the change and key_press[0] is high for 1 cycle. Releasing then gives key_release[0] for 1 cycle after 6 edges.
- Bounce rejection: key_in[1] pulsed low for 3 cycles, high 2, low 3 -> key_level[1] stays 0 and no key_press/key_release on any channel.
- Toggle mode (LED_MODE=1): three clean presses/releases on key 2 -> led_out[2] sequence 1,0,1, changing only on press edges. led_out[0,1,3] stay 0.
- Reset mid-count: key 3 pressed, rst asserted at cnt=2 for 1 cycle while held -> no pulse. key_press[3] appears 6 edges after rst deasserts.
- Simultaneous channels and extreme parameter: keys 0 and 3 pressed in the same cycle -> key_press=4'b1001 in one cycle. With DEBOUNCE_CYCLES=1, a press gives key_level after 3 edges.
